req_ack_done_responder: RTL

- Responder side of the req/ack/done handshake.
- The initiator raises req and holds it. This block answers with ack after a programmable latency, then done after a second latency.
- ack and done are held until the initiator drops req (4-phase return-to-zero).
- Acts as the slave model/RTL that the req→eventually ack→done assertion set checks.

---
 rtl/req_ack_done_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/req_ack_done_responder.sv
// req_ack_done_responder: 4-phase req/ack/done responder with programmable ack and done latencies
module req_ack_done_responder #(
  parameter int ACK_DLY  = 4,
  parameter int DONE_DLY = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             hold,
  output logic             ack,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] job_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, RELEASE} state_t;
  localparam logic [7:0] ACK_LD  = 8'(ACK_DLY - 1);
  localparam logic [7:0] DONE_LD = 8'(DONE_DLY - 1);
  if (ACK_DLY < 1 || ACK_DLY > 255 || DONE_DLY < 1 || DONE_DLY > 255) begin : g_bad_dly
    $fatal(1, "req_ack_done_responder: ACK_DLY and DONE_DLY must be 1..255");
  end
  state_t     state;
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      job_cnt <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE:
          if (req) begin
            busy <= 1'b1;
            if (ACK_DLY == 1) begin
              ack   <= 1'b1;
              cnt   <= DONE_LD;
              state <= WAIT_DONE;
            end else begin
              cnt   <= ACK_LD;
              state <= WAIT_ACK;
            end
          end
        WAIT_ACK, WAIT_DONE:
          // abort outranks both hold and expiry on the same edge
          if (!req) begin
            err   <= 1'b1;
            ack   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else if (!hold) begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else if (state == WAIT_ACK) begin
              ack   <= 1'b1;
              cnt   <= DONE_LD;
              state <= WAIT_DONE;
            end else begin
              done  <= 1'b1;
              state <= RELEASE;
            end
          end
        RELEASE:
          if (!req) begin
            ack     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            job_cnt <= job_cnt + CNT_W'(1);
            state   <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
